// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Brief    : Steps the tone datapath through a fixed song: one 3-bit control
//            vector per note, a silent gap after each note, one-hot note
//            LEDs, and a sticky timeout flag. Define NOTE_SEQ_LOOP_EN to
//            replay the song continuously instead of a single pass.
// Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int                     NUM_NOTES      = 6,
    parameter logic [3*NUM_NOTES-1:0] SONG           = 18'o654321,
    parameter int                     GAP_CYCLES     = 1000,
    parameter int                     TIMEOUT_CYCLES = 10000000,
    parameter int                     TO_W           = 24
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       play,
    input  logic       done,
    output logic [2:0] cv,
    output logic       led0,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic       led5,
    output logic       busy,
    output logic       song_done,
    output logic       err
);

    localparam logic [2:0]      c_st_idle   = 3'd0;
    localparam logic [2:0]      c_st_load   = 3'd1;
    localparam logic [2:0]      c_st_play   = 3'd2;
    localparam logic [2:0]      c_st_gap    = 3'd3;
    localparam logic [2:0]      c_st_finish = 3'd4;

    localparam logic [3:0]      c_last_idx  = 4'(NUM_NOTES - 1);
    localparam logic [TO_W-1:0] c_to_last   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] c_gap_last  = TO_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    logic             r_play_s1, r_play_s2, r_play_s3, r_play_pulse;
    logic [2:0]       r_state, w_state_nxt;
    logic [3:0]       r_idx, w_idx_nxt;
    logic [TO_W-1:0]  r_cnt;
    logic             r_err, w_err_nxt;
    logic             w_wrap;
    logic [2:0]       r_cv;
    logic [5:0]       r_leds, w_leds_nxt;
    logic [3:0]       w_led_sel;
    logic             r_busy, r_song_done;
    logic [15:0][2:0] w_codes;
    logic [2:0]       w_code;

    // play is asynchronous: two flops resolve metastability, the third gives the edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_play_s1    <= 1'b0;
            r_play_s2    <= 1'b0;
            r_play_s3    <= 1'b0;
            r_play_pulse <= 1'b0;
        end else begin
            r_play_s1    <= play;
            r_play_s2    <= r_play_s1;
            r_play_s3    <= r_play_s2;
            r_play_pulse <= r_play_s2 & ~r_play_s3;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_codes
            if (gi < NUM_NOTES) begin : g_used
                assign w_codes[gi] = SONG[3*gi +: 3];
            end else begin : g_unused
                assign w_codes[gi] = 3'd0;
            end
        end
    endgenerate

    assign w_code = w_codes[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_wrap      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_play_pulse) begin
                    w_state_nxt = c_st_load;
                    w_idx_nxt   = 4'd0;
                    w_err_nxt   = 1'b0;
                end
            end
            c_st_load: begin
                if (r_play_pulse)        w_state_nxt = c_st_idle;
                else if (w_code == 3'd0) w_state_nxt = c_st_finish;
                else                     w_state_nxt = c_st_play;
            end
            c_st_play: begin
                // a play press aborts first; done beats a timeout on the same cycle
                if (r_play_pulse)            w_state_nxt = c_st_idle;
                else if (done)               w_state_nxt = c_st_gap;
                else if (r_cnt == c_to_last) begin
                    w_state_nxt = c_st_finish;
                    w_err_nxt   = 1'b1;
                end
            end
            c_st_gap: begin
                if (r_play_pulse) begin
                    w_state_nxt = c_st_idle;
                end else if (r_cnt >= c_gap_last) begin
                    if (r_idx == c_last_idx) begin
`ifdef NOTE_SEQ_LOOP_EN
                        w_state_nxt = c_st_load;
                        w_idx_nxt   = 4'd0;
                        w_wrap      = 1'b1;
`else
                        w_state_nxt = c_st_finish;
`endif
                    end else begin
                        w_state_nxt = c_st_load;
                        w_idx_nxt   = r_idx + 4'd1;
                    end
                end
            end
            c_st_finish: w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    assign w_led_sel = w_idx_nxt % 4'd6;

    always_comb begin
        w_leds_nxt = 6'd0;
        if (w_state_nxt == c_st_load || w_state_nxt == c_st_play || w_state_nxt == c_st_gap)
            w_leds_nxt = 6'b000001 << w_led_sel;
    end

    // outputs are registered from the next state so they line up with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_idx       <= 4'd0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_cv        <= 3'd0;
            r_leds      <= 6'd0;
            r_busy      <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state == c_st_play || r_state == c_st_gap)
                r_cnt <= r_cnt + TO_W'(1);
            r_cv        <= (w_state_nxt == c_st_play) ? w_code : 3'd0;
            r_leds      <= w_leds_nxt;
            r_busy      <= (w_state_nxt != c_st_idle);
            r_song_done <= (w_state_nxt == c_st_finish) | w_wrap;
        end
    end

    assign cv        = r_cv;
    assign led0      = r_leds[0];
    assign led1      = r_leds[1];
    assign led2      = r_leds[2];
    assign led3      = r_leds[3];
    assign led4      = r_leds[4];
    assign led5      = r_leds[5];
    assign busy      = r_busy;
    assign song_done = r_song_done;
    assign err       = r_err;

endmodule
`default_nettype wire
